// File: rtl/seg_score_display.sv
// BCD score counter with a frame snapshot and a two-stage seven-segment pixel renderer.
// Answers "is this pixel lit" for a row of NUM_DIGITS glyphs at one pixel per clock.
module seg_score_display #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEG_L      = 6,
  parameter int unsigned SEG_W      = 2,
  parameter int unsigned GAP        = 4,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    score_inc,
  input  logic                    score_clr,
  input  logic                    frame_start,
  input  logic                    blank_lead,
  input  logic [X_W-1:0]          origin_x,
  input  logic [Y_W-1:0]          origin_y,
  input  logic [X_W-1:0]          pix_x,
  input  logic [Y_W-1:0]          pix_y,
  input  logic                    pix_valid,
  output logic                    pix_on,
  output logic                    pix_on_valid,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic                    overflow
);

  localparam int unsigned CW   = SEG_L + 2 * SEG_W;
  localparam int unsigned CH   = 2 * SEG_L + 3 * SEG_W;
  localparam int unsigned P    = CW + GAP;
  localparam int unsigned SPAN = NUM_DIGITS * P;
  localparam int unsigned KW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SW   = 4 * NUM_DIGITS;

  localparam logic [X_W-1:0] P_X    = X_W'(P);
  localparam logic [X_W-1:0] SPAN_X = X_W'(SPAN);
  localparam logic [X_W-1:0] CW_X   = X_W'(CW);
  localparam logic [X_W-1:0] XM0    = X_W'(SEG_W);
  localparam logic [X_W-1:0] XM1    = X_W'(SEG_W + SEG_L);
  localparam logic [X_W-1:0] XR0    = X_W'(CW - SEG_W);
  localparam logic [Y_W-1:0] CH_Y   = Y_W'(CH);
  localparam logic [Y_W-1:0] Y1     = Y_W'(SEG_W);
  localparam logic [Y_W-1:0] Y2     = Y_W'(SEG_W + SEG_L);
  localparam logic [Y_W-1:0] Y3     = Y_W'(2 * SEG_W + SEG_L);
  localparam logic [Y_W-1:0] Y4     = Y_W'(2 * SEG_W + 2 * SEG_L);
  localparam logic [KW-1:0]  K_LAST = KW'(NUM_DIGITS - 1);

  localparam logic [SW-1:0]  ALL_NINES = {NUM_DIGITS{4'h9}};

  // abcdefg, a in bit 6
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Score counter and snapshot
  // ---------------------------------------------------------------------------
  logic [SW-1:0] score_q, score_d;
  logic [SW-1:0] snap_q;
  logic          ovf_q, ovf_d;
  logic [3:0]    inc_dig;
  logic          carry;

  // Digit 0 (leftmost) lives in the MSBs, so the ripple runs from bit 0 upwards.
  always_comb begin
    score_d = score_q;
    ovf_d   = ovf_q;
    inc_dig = 4'd0;
    carry   = 1'b0;
    if (score_clr) begin
      score_d = '0;
      ovf_d   = 1'b0;
    end else if (score_inc) begin
      if (score_q == ALL_NINES) begin
        ovf_d = 1'b1;
      end else begin
        carry = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          inc_dig = score_q[4*i +: 4];
          if (carry) begin
            if (inc_dig >= 4'd9) begin
              score_d[4*i +: 4] = 4'd0;
            end else begin
              score_d[4*i +: 4] = inc_dig + 4'd1;
              carry             = 1'b0;
            end
          end
        end
      end
    end
  end

  // The snapshot copies score_q, i.e. the value before any same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
      ovf_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      score_q <= score_d;
      ovf_q   <= ovf_d;
      if (frame_start) begin
        snap_q <= score_q;
      end
    end
  end

  assign score_bcd = score_q;
  assign overflow  = ovf_q;

  // ---------------------------------------------------------------------------
  // Stage 1: cell selection and local coordinates
  // ---------------------------------------------------------------------------
  logic [X_W-1:0] dx, k_full, lx;
  logic [Y_W-1:0] dy;
  logic           in_bounds;

  always_comb begin
    dx        = pix_x - origin_x;
    dy        = pix_y - origin_y;
    in_bounds = (pix_x >= origin_x) && (pix_y >= origin_y) && (dy < CH_Y) && (dx < SPAN_X);
    k_full    = dx / P_X;
    lx        = dx - k_full * P_X;
  end

  logic           s1_valid_q;
  logic           s1_inb_q;
  logic [KW-1:0]  s1_k_q;
  logic [X_W-1:0] s1_lx_q;
  logic [Y_W-1:0] s1_ly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_inb_q   <= 1'b0;
      s1_k_q     <= '0;
      s1_lx_q    <= '0;
      s1_ly_q    <= '0;
    end else begin
      s1_valid_q <= pix_valid;
      s1_inb_q   <= pix_valid && in_bounds;
      s1_k_q     <= KW'(k_full);
      s1_lx_q    <= lx;
      s1_ly_q    <= dy;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: segment hit, glyph decode, leading-zero blanking
  // ---------------------------------------------------------------------------
  logic [3:0]            snap_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [6:0]            seg_lit;
  logic [6:0]            seg_hit;
  logic                  x_mid, x_left, x_right, y_upper, y_lower;
  logic                  blank_dig;
  logic                  on_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      snap_dig[i] = snap_q[SW-1-4*i -: 4];
    end
    lead_zero[0] = (snap_dig[0] == 4'd0);
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      lead_zero[i] = lead_zero[i-1] && (snap_dig[i] == 4'd0);
    end
  end

  always_comb begin
    x_mid   = (s1_lx_q >= XM0) && (s1_lx_q < XM1);
    x_left  = (s1_lx_q < XM0);
    x_right = (s1_lx_q >= XR0) && (s1_lx_q < CW_X);
    y_upper = (s1_ly_q >= Y1) && (s1_ly_q < Y2);
    y_lower = (s1_ly_q >= Y3) && (s1_ly_q < Y4);

    seg_hit[6] = x_mid && (s1_ly_q < Y1);                    // a
    seg_hit[5] = x_right && y_upper;                         // b
    seg_hit[4] = x_right && y_lower;                         // c
    seg_hit[3] = x_mid && (s1_ly_q >= Y4) && (s1_ly_q < CH_Y); // d
    seg_hit[2] = x_left && y_lower;                          // e
    seg_hit[1] = x_left && y_upper;                          // f
    seg_hit[0] = x_mid && (s1_ly_q >= Y2) && (s1_ly_q < Y3); // g

    seg_lit   = seg_decode(snap_dig[s1_k_q]);
    // The rightmost digit is never blanked so a zero score still shows "0".
    blank_dig = blank_lead && lead_zero[s1_k_q] && (s1_k_q != K_LAST);
    on_d      = s1_valid_q && s1_inb_q && (s1_lx_q < CW_X) && (|(seg_hit & seg_lit)) &&
                !blank_dig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_on       <= 1'b0;
      pix_on_valid <= 1'b0;
    end else begin
      pix_on       <= on_d;
      pix_on_valid <= s1_valid_q;
    end
  end

endmodule
